// File: rtl/ks10_bus_arbiter.sv
// KS10 backplane bus arbiter: round-robin grant, one-cycle request strobe,
// acknowledge/data return path and non-existent-device (NXM) timeout.
//
// Ports:
//   clk, rst        bus clock (rising edge), async active-low reset
//   devREQO[N]      per-device request
//   devACKO[N]      per-device acknowledge
//   devADDRO[N*36]  per-device address, device i at [36*i +: 36]
//   devDATAO[N*36]  per-device data, device i at [36*i +: 36]
//   devINTRO[N*7]   per-device interrupt lines, device i at [7*i +: 7]
//   busREQI         one-cycle broadcast request strobe
//   busADDRI[36]    address of the granted cycle
//   busDATAI[36]    write data during REQ, read data after ACK
//   busINTRI[7]     registered OR of all device interrupt lines
//   devACKI[N]      acknowledge pulse to the granted requester
//   devNXM[N]       timeout pulse to the granted requester
//   grant[N]        one-hot current owner, 0 when idle
module ks10_bus_arbiter #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NDEV-1:0]    devREQO,
    input  logic [NDEV-1:0]    devACKO,
    input  logic [NDEV*36-1:0] devADDRO,
    input  logic [NDEV*36-1:0] devDATAO,
    input  logic [NDEV*7-1:0]  devINTRO,
    output logic               busREQI,
    output logic [35:0]        busADDRI,
    output logic [35:0]        busDATAI,
    output logic [6:0]         busINTRI,
    output logic [NDEV-1:0]    devACKI,
    output logic [NDEV-1:0]    devNXM,
    output logic [NDEV-1:0]    grant
);

    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      timer_q, timer_d;
    logic            req_q, req_d;
    logic [35:0]     addr_q, addr_d;
    logic [35:0]     data_q, data_d;
    logic [6:0]      intr_q, intr_d;
    logic [NDEV-1:0] ack_q, ack_d;
    logic [NDEV-1:0] nxm_q, nxm_d;
    logic [NDEV-1:0] grant_q, grant_d;

    logic [35:0]     addr_a [NDEV];
    logic [35:0]     data_a [NDEV];
    logic [IW-1:0]   cand   [NDEV];

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   pick_nxt;
    logic [NDEV-1:0] ack_mask;
    logic            ack_vld;
    logic [IW-1:0]   resp_idx;
    logic            expired;

    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            addr_a[i] = devADDRO[36*i +: 36];
            data_a[i] = devDATAO[36*i +: 36];
        end
    end

    // Search order: rr_q, rr_q+1, ... wrapping back to rr_q-1.
    always_comb begin
        for (int k = 0; k < NDEV; k++) begin
            cand[k] = IW'((int'(rr_q) + k) % NDEV);
        end
    end

    // Scanning downward lets the earliest candidate overwrite later ones.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (devREQO[cand[k]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[k];
            end
        end
    end

    assign pick_nxt = (pick_idx == IW'(NDEV - 1)) ? '0
                                                  : pick_idx + 1'b1;

    // The requester's own ACKO is ignored; lowest remaining index wins.
    assign ack_mask = devACKO & ~grant_q;

    always_comb begin
        ack_vld  = 1'b0;
        resp_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (ack_mask[i]) begin
                ack_vld  = 1'b1;
                resp_idx = IW'(i);
            end
        end
    end

    assign expired = (timer_q == TMAX);

    always_comb begin
        intr_d = '0;
        for (int i = 0; i < NDEV; i++) begin
            intr_d = intr_d | devINTRO[7*i +: 7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (pick_vld) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (ack_vld || expired) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        timer_d = timer_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ack_d   = ack_q;
        nxm_d   = nxm_q;
        grant_d = grant_q;
        unique case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (pick_vld) begin
                    req_d   = 1'b1;
                    addr_d  = addr_a[pick_idx];
                    data_d  = data_a[pick_idx];
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                    timer_d = '0;
                    rr_d    = pick_nxt;
                end
            end
            S_REQ: begin
                req_d = 1'b0;
            end
            S_WAIT: begin
                if (ack_vld) begin
                    data_d = data_a[resp_idx];
                    ack_d  = grant_q;
                end else if (expired) begin
                    nxm_d = grant_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                ack_d   = '0;
                nxm_d   = '0;
                grant_d = '0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q    <= '0;
            timer_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            intr_q  <= '0;
            ack_q   <= '0;
            nxm_q   <= '0;
            grant_q <= '0;
        end else begin
            rr_q    <= rr_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            intr_q  <= intr_d;
            ack_q   <= ack_d;
            nxm_q   <= nxm_d;
            grant_q <= grant_d;
        end
    end

    assign busREQI  = req_q;
    assign busADDRI = addr_q;
    assign busDATAI = data_q;
    assign busINTRI = intr_q;
    assign devACKI  = ack_q;
    assign devNXM   = nxm_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// Testbench for ks10_bus_arbiter: transaction-level reference model
// (round-robin pick, lowest responder, timeout) against random traffic.
module tb_ks10_bus_arbiter;

    localparam int NDEV = 4;
    localparam int TO   = 63;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NDEV-1:0]    devREQO = '0;
    logic [NDEV-1:0]    devACKO = '0;
    logic [NDEV*36-1:0] devADDRO = '0;
    logic [NDEV*36-1:0] devDATAO = '0;
    logic [NDEV*7-1:0]  devINTRO = '0;
    logic               busREQI;
    logic [35:0]        busADDRI;
    logic [35:0]        busDATAI;
    logic [6:0]         busINTRI;
    logic [NDEV-1:0]    devACKI;
    logic [NDEV-1:0]    devNXM;
    logic [NDEV-1:0]    grant;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int m_rr   = 0;

    logic [35:0] addr_v [NDEV];
    logic [35:0] data_v [NDEV];

    ks10_bus_arbiter #(.NDEV(NDEV), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .devREQO  (devREQO),
        .devACKO  (devACKO),
        .devADDRO (devADDRO),
        .devDATAO (devDATAO),
        .devINTRO (devINTRO),
        .busREQI  (busREQI),
        .busADDRI (busADDRI),
        .busDATAI (busDATAI),
        .busINTRI (busINTRI),
        .devACKI  (devACKI),
        .devNXM   (devNXM),
        .grant    (grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [NDEV-1:0] r, input int p);
        for (int k = 0; k < NDEV; k++)
            if (r[(p + k) % NDEV]) return (p + k) % NDEV;
        return -1;
    endfunction

    function automatic int lowest(input logic [NDEV-1:0] m);
        for (int i = 0; i < NDEV; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [6:0] intr_or(input logic [NDEV*7-1:0] v);
        logic [6:0] o = '0;
        for (int i = 0; i < NDEV; i++) o = o | v[7*i +: 7];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vals();
        for (int i = 0; i < NDEV; i++) begin
            devADDRO[36*i +: 36] = addr_v[i];
            devDATAO[36*i +: 36] = data_v[i];
        end
    endtask

    task automatic rand_vals();
        logic [63:0] r;
        for (int i = 0; i < NDEV; i++) begin
            r = {$urandom(), $urandom()};
            addr_v[i] = r[35:0];
            r = {$urandom(), $urandom()};
            data_v[i] = r[35:0];
        end
        load_vals();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        devREQO = '0;
        devACKO = '0;
        devINTRO = '0;
        tick();
        tick();
        rst = 1'b1;
        m_rr = 0;
    endtask

    // One full transaction; expectations come from the rr pointer model.
    task automatic run_txn(
        input  string           nm,
        input  logic [NDEV-1:0] reqs,
        input  logic [NDEV-1:0] ackers,
        input  bit              self_ack,
        input  int              d,
        input  bit              hold,
        output logic [NDEV-1:0] gobs,
        output int              gcyc,
        output int              rcyc
    );
        int eg;
        int rs;
        logic [NDEV-1:0] oh;
        logic [NDEV-1:0] eff;
        logic [35:0] xd;
        eg = rr_pick(reqs, m_rr);
        m_rr = (eg + 1) % NDEV;
        oh = '0;
        oh[eg] = 1'b1;
        eff = ackers & ~oh;
        devREQO = reqs;
        tick();
        gobs = grant;
        gcyc = cyc;
        checks++;
        if ({busREQI, grant, busADDRI, busDATAI} !==
            {1'b1, oh, addr_v[eg], data_v[eg]}) begin
            fails++;
            $display("FAIL %s grant: got req=%b g=%b a=%o d=%o want req=1 g=%b a=%o d=%o",
                     nm, busREQI, grant, busADDRI, busDATAI,
                     oh, addr_v[eg], data_v[eg]);
        end
        if (!hold) devREQO = '0;
        tick();
        checks++;
        if ({busREQI, grant, busADDRI, devACKI, devNXM} !==
            {1'b0, oh, addr_v[eg], {NDEV{1'b0}}, {NDEV{1'b0}}}) begin
            fails++;
            $display("FAIL %s req_end: got req=%b g=%b a=%o ack=%b nxm=%b want req=0 g=%b a=%o",
                     nm, busREQI, grant, busADDRI, devACKI, devNXM,
                     oh, addr_v[eg]);
        end
        xd = data_v[eg];
        rcyc = -1;
        for (int t = 0; t < TO; t++) begin
            devACKO = (self_ack ? oh : '0) | ((t == d) ? ackers : '0);
            tick();
            checks++;
            if (t == d && eff != 0) begin
                rs = lowest(eff);
                xd = data_v[rs];
                rcyc = cyc;
                if ({devACKI, devNXM, grant, busDATAI} !==
                    {oh, {NDEV{1'b0}}, oh, xd}) begin
                    fails++;
                    $display("FAIL %s ack: got ack=%b nxm=%b g=%b d=%o want ack=%b nxm=0 d=%o",
                             nm, devACKI, devNXM, grant, busDATAI, oh, xd);
                end
                break;
            end else if (t == TO - 1) begin
                rcyc = cyc;
                if ({devACKI, devNXM, grant, busDATAI} !==
                    {{NDEV{1'b0}}, oh, oh, xd}) begin
                    fails++;
                    $display("FAIL %s nxm: got ack=%b nxm=%b g=%b d=%o want ack=0 nxm=%b d=%o",
                             nm, devACKI, devNXM, grant, busDATAI, oh, xd);
                end
            end else if ({devACKI, devNXM, busREQI, grant, busDATAI} !==
                         {{NDEV{1'b0}}, {NDEV{1'b0}}, 1'b0, oh, xd}) begin
                fails++;
                $display("FAIL %s wait t=%0d: got ack=%b nxm=%b req=%b g=%b d=%o want g=%b d=%o",
                         nm, t, devACKI, devNXM, busREQI, grant, busDATAI, oh, xd);
            end
        end
        devACKO = '0;
        tick();
        checks++;
        if ({devACKI, devNXM, grant, busREQI, busDATAI} !==
            {{NDEV{1'b0}}, {NDEV{1'b0}}, {NDEV{1'b0}}, 1'b0, xd}) begin
            fails++;
            $display("FAIL %s done: got ack=%b nxm=%b g=%b req=%b d=%o want zeros d=%o",
                     nm, devACKI, devNXM, grant, busREQI, busDATAI, xd);
        end
    endtask

    task automatic test_reset();
        devREQO = 4'b1111;
        devINTRO = '1;
        tick();
        tick();
        checks++;
        if ({busREQI, busADDRI, busDATAI, busINTRI, devACKI, devNXM, grant} !== '0) begin
            fails++;
            $display("FAIL reset_hold: got req=%b g=%b intr=%b want all zero",
                     busREQI, grant, busINTRI);
        end
        devREQO = '0;
        devINTRO = '0;
        rst = 1'b1;
        m_rr = 0;
        tick();
        checks++;
        if ({busREQI, devACKI, devNXM, grant} !== '0) begin
            fails++;
            $display("FAIL reset_idle: got req=%b g=%b want 0", busREQI, grant);
        end
    endtask

    task automatic test_basic();
        logic [NDEV-1:0] g;
        int gc, rc;
        do_reset();
        rand_vals();
        addr_v[0] = 36'o000000001000;
        data_v[0] = 36'o123;
        data_v[2] = 36'o777;
        load_vals();
        run_txn("basic", 4'b0001, 4'b0100, 1'b0, 0, 1'b0, g, gc, rc);
        checks++;
        if (rc - gc !== 2) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 2", rc - gc);
        end
    endtask

    task automatic test_timeout();
        logic [NDEV-1:0] g;
        int gc, rc;
        do_reset();
        rand_vals();
        run_txn("timeout", 4'b0010, 4'b0000, 1'b0, 1000, 1'b0, g, gc, rc);
        // busREQI ends one edge after the grant; NXM comes TO edges later.
        checks++;
        if (rc - gc !== TO + 1) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d want %0d", rc - gc, TO + 1);
        end
    endtask

    task automatic test_back_to_back();
        int order [6] = '{0, 1, 3, 0, 1, 3};
        logic [NDEV-1:0] g;
        logic [NDEV-1:0] want;
        int gc, rc, prev;
        do_reset();
        rand_vals();
        prev = -1;
        for (int n = 0; n < 6; n++) begin
            run_txn("rr", 4'b1011, 4'b0100, 1'b0, 0, 1'b1, g, gc, rc);
            want = '0;
            want[order[n]] = 1'b1;
            checks++;
            if (g !== want) begin
                fails++;
                $display("FAIL rr_order n=%0d: got %b want %b", n, g, want);
            end
            if (prev >= 0) begin
                checks++;
                if (gc - prev !== 4) begin
                    fails++;
                    $display("FAIL b2b_spacing n=%0d: got %0d want 4", n, gc - prev);
                end
            end
            prev = gc;
        end
        devREQO = '0;
        tick();
    endtask

    task automatic test_ack_select();
        logic [NDEV-1:0] g;
        int gc, rc;
        do_reset();
        rand_vals();
        run_txn("selfack", 4'b0001, 4'b1000, 1'b1, 3, 1'b0, g, gc, rc);
        rand_vals();
        run_txn("dual_ack", 4'b0001, 4'b1010, 1'b0, 0, 1'b0, g, gc, rc);
        rand_vals();
        run_txn("ack_at_to", 4'b0100, 4'b0001, 1'b0, TO - 1, 1'b0, g, gc, rc);
        rand_vals();
        run_txn("only_self", 4'b0001, 4'b0001, 1'b1, 2, 1'b0, g, gc, rc);
    endtask

    task automatic test_random();
        logic [NDEV-1:0] g;
        logic [NDEV-1:0] r, a;
        int gc, rc, d;
        bit s;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            rand_vals();
            r = NDEV'($urandom_range(1, 15));
            a = NDEV'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) d = TO - 1;
            run_txn("random", r, a, s, d, 1'b0, g, gc, rc);
        end
    endtask

    task automatic test_intr();
        logic [6:0] w;
        do_reset();
        devINTRO = '0;
        devINTRO[6:0]   = 7'b0000100;
        devINTRO[20:14] = 7'b1000000;
        tick();
        checks++;
        if (busINTRI !== 7'b1000100) begin
            fails++;
            $display("FAIL intr_fixed: got %b want 1000100", busINTRI);
        end
        for (int n = 0; n < 5; n++) begin
            devINTRO = NDEV*7'({$urandom(), $urandom()});
            w = intr_or(devINTRO);
            tick();
            checks++;
            if (busINTRI !== w) begin
                fails++;
                $display("FAIL intr_rand: got %b want %b", busINTRI, w);
            end
        end
        rand_vals();
        devREQO = 4'b0001;
        tick();
        devREQO = '0;
        tick();
        devINTRO = NDEV*7'({$urandom(), $urandom()});
        w = intr_or(devINTRO);
        tick();
        checks++;
        if ({busINTRI, grant, busREQI} !== {w, 4'b0001, 1'b0}) begin
            fails++;
            $display("FAIL intr_wait: got intr=%b g=%b want intr=%b g=0001",
                     busINTRI, grant, w);
        end
        do_reset();
    endtask

    task automatic test_reset_wait();
        logic [NDEV-1:0] g;
        int gc, rc;
        bit bad;
        do_reset();
        rand_vals();
        devINTRO = '1;
        devREQO = 4'b0100;
        tick();
        devREQO = '0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busREQI, busADDRI, busDATAI, busINTRI, devACKI, devNXM, grant} !== '0) begin
            fails++;
            $display("FAIL reset_async: got g=%b intr=%b a=%o want all zero",
                     grant, busINTRI, busADDRI);
        end
        tick();
        devINTRO = '0;
        rst = 1'b1;
        m_rr = 0;
        bad = 1'b0;
        for (int n = 0; n < TO + 8; n++) begin
            tick();
            if ({busREQI, devACKI, devNXM, grant} !== '0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL reset_stale: got stale=%b want 0", bad);
        end
        run_txn("post_reset", 4'b1010, 4'b0001, 1'b0, 1, 1'b0, g, gc, rc);
        checks++;
        if (g !== 4'b0010) begin
            fails++;
            $display("FAIL post_reset_grant: got %b want 0010", g);
        end
    endtask

    initial begin
        for (int i = 0; i < NDEV; i++) begin
            addr_v[i] = '0;
            data_v[i] = '0;
        end
        test_reset();
        test_basic();
        test_timeout();
        test_back_to_back();
        test_ack_select();
        test_intr();
        test_reset_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
